// File: rtl/stud_sync_word_qualifier.sv
// rtl/stud_sync_word_qualifier.sv - qualifies a synchronized multi-bit word by stability and hands it downstream once
module stud_sync_word_qualifier #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    input  logic             clr_ovr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   c_q, c_d;
    logic               have_last_q, have_last_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

    logic               sample_changed;
    logic               word_qualified;
    logic               word_is_new;
    logic               capture;
    logic               handshake;
    logic               overrun_set;

    // Shared qualification terms used by both the FSM and the datapath.
    always_comb begin
        sample_changed = (data_i != s_q);
        word_qualified = (c_q == C_MAX);
        // First word after reset/enable is always new, even if it matches the old data_o.
        word_is_new    = !have_last_q || (s_q != data_q);
        capture        = enable_i && (state_q == ST_TRACK) && word_qualified && word_is_new;
        handshake      = enable_i && (state_q == ST_HOLD) && ready_i;
        // A qualified, undelivered word that is about to be replaced while the consumer stalls.
        overrun_set    = (state_q == ST_HOLD) && !ready_i && word_qualified
                         && (s_q != data_q) && sample_changed;
    end

    // State register and all datapath flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            c_q         <= '0;
            have_last_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            have_last_q <= have_last_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic; disabling always returns to IDLE regardless of state.
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_TRACK;
                ST_TRACK: if (capture) state_d = ST_HOLD;
                ST_HOLD:  if (ready_i) state_d = ST_TRACK;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output and tracking logic: stability counter, capture, handshake, sticky overrun.
    always_comb begin
        s_d         = s_q;
        c_d         = c_q;
        have_last_d = have_last_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;

        if (!enable_i || (state_q == ST_IDLE)) begin
            // IDLE holds the tracker cleared; data_o is retained across a disable.
            s_d         = '0;
            c_d         = '0;
            have_last_d = 1'b0;
            valid_d     = 1'b0;
        end else begin
            // The tracker keeps running in HOLD so a later word can qualify meanwhile.
            if (sample_changed) begin
                s_d = data_i;
                c_d = C_ONE;
            end else if (c_q != C_MAX) begin
                c_d = c_q + C_ONE;
            end

            if (capture) begin
                data_d      = s_q;
                valid_d     = 1'b1;
                have_last_d = 1'b1;
            end

            // Capture is only possible from TRACK, so valid_o drops for at least one cycle.
            if (handshake) begin
                valid_d = 1'b0;
            end
        end

        // Set has priority over clear.
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clr_ovr_i) begin
            overrun_d = 1'b0;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_stud_sync_word_qualifier.sv
// tb/tb_stud_sync_word_qualifier.sv - directed self-checking bench for stud_sync_word_qualifier
module tb_stud_sync_word_qualifier;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        ready_i = 1'b0;
    logic        clr_ovr_i = 1'b0;
    logic [15:0] data_o;
    logic        valid_o;
    logic        overrun_o;

    int checks = 0;
    int failures = 0;

    stud_sync_word_qualifier #(
        .WIDTH(16),
        .STABLE_CYCLES(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .enable_i(enable_i),
        .data_i(data_i),
        .ready_i(ready_i),
        .clr_ovr_i(clr_ovr_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic seen_valid;
        logic seen_ovr;

        // Reset
        step();
        rst_i = 1'b0;
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_ovr", 32'(overrun_o), 32'h0);

        // 1: first word qualifies after 4 stable samples, held until ready
        enable_i = 1'b1;
        step();                       // IDLE -> TRACK
        data_i = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_wait_valid", 32'(valid_o), 32'h0);
        end
        step();
        check("t1_valid", 32'(valid_o), 32'h1);
        check("t1_data", 32'(data_o), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_hold_valid", 32'(valid_o), 32'h1);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check("t1_after_ready", 32'(valid_o), 32'h0);
        check("t1_data_kept", 32'(data_o), 32'h1234);

        // 3: same word held after delivery -> no re-delivery, no overrun
        seen_valid = 1'b0;
        seen_ovr = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            seen_valid |= valid_o;
            seen_ovr |= overrun_o;
        end
        check("t3_no_redeliver", 32'(seen_valid), 32'h0);
        check("t3_no_overrun", 32'(seen_ovr), 32'h0);

        // 2: short-lived word discarded, next stable word delivered
        data_i = 16'h00AA;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t2_aa_valid", 32'(valid_o), 32'h0);
        end
        data_i = 16'h00AB;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_ab_wait", 32'(valid_o), 32'h0);
        end
        step();
        check("t2_valid", 32'(valid_o), 32'h1);
        check("t2_data", 32'(data_o), 32'h00AB);

        // 4: overrun under backpressure, then delivery of the replacing word
        data_i = 16'h5555;
        for (int i = 0; i < 4; i++) step();
        check("t4_no_ovr_yet", 32'(overrun_o), 32'h0);
        check("t4_hold_data", 32'(data_o), 32'h00AB);
        data_i = 16'h6666;
        step();
        check("t4_ovr_set", 32'(overrun_o), 32'h1);
        check("t4_still_valid", 32'(valid_o), 32'h1);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check("t4_hs_valid", 32'(valid_o), 32'h0);
        step();
        check("t4_gap1", 32'(valid_o), 32'h0);
        step();
        check("t4_gap2", 32'(valid_o), 32'h0);
        step();
        check("t4_valid", 32'(valid_o), 32'h1);
        check("t4_data", 32'(data_o), 32'h6666);
        check("t4_ovr_sticky", 32'(overrun_o), 32'h1);
        clr_ovr_i = 1'b1;
        step();
        clr_ovr_i = 1'b0;
        check("t4_ovr_clr", 32'(overrun_o), 32'h0);

        // 5: disable while valid, re-enable with the same word -> redelivered
        enable_i = 1'b0;
        step();
        check("t5_dis_valid", 32'(valid_o), 32'h0);
        check("t5_dis_data", 32'(data_o), 32'h6666);
        enable_i = 1'b1;
        step();                       // IDLE -> TRACK
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_wait", 32'(valid_o), 32'h0);
        end
        step();
        check("t5_redeliver", 32'(valid_o), 32'h1);
        check("t5_data", 32'(data_o), 32'h6666);

        // 6: reset mid-HOLD with overrun pending
        data_i = 16'h7777;
        for (int i = 0; i < 4; i++) step();
        data_i = 16'h8888;
        step();
        check("t6_pre_ovr", 32'(overrun_o), 32'h1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("t6_rst_data", 32'(data_o), 32'h0);
        check("t6_rst_valid", 32'(valid_o), 32'h0);
        check("t6_rst_ovr", 32'(overrun_o), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_restart_wait", 32'(valid_o), 32'h0);
        end
        step();
        check("t6_valid", 32'(valid_o), 32'h1);
        check("t6_data", 32'(data_o), 32'h8888);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
